// File: rtl/loader_pkg.sv
// Shared types and constants for the serial program loader.
package loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StMagic,
        StCntLo,
        StCntHi,
        StData,
        StCsum,
        StDone,
        StErr
    } state_e;

    localparam logic [7:0] MagicByte = 8'hA5;
    localparam int unsigned CountW = 16;

endpackage

// File: rtl/word_assembler.sv
// Packs received bytes little-endian into 32-bit words and pulses word_valid_o
// the cycle after the fourth byte of each word.
module word_assembler (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    output logic        last_byte_o,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [1:0]  idx_q;
    logic [31:0] word_q;
    logic        valid_q;

    assign last_byte_o  = (idx_q == 2'd3);
    assign word_valid_o = valid_q;
    assign word_o       = word_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_q   <= 2'd0;
            word_q  <= 32'd0;
            valid_q <= 1'b0;
        end else if (clear_i) begin
            idx_q   <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= byte_valid_i && (idx_q == 2'd3);
            if (byte_valid_i) begin
                word_q[8*idx_q +: 8] <= byte_data_i;
                idx_q                <= idx_q + 2'd1;
            end
        end
    end

endmodule

// File: rtl/program_loader.sv
// Receives a framed program image over a byte stream, writes it into instruction
// memory and releases the CPU from reset once the checksum verifies.
module program_loader
    import loader_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 1000000,
    parameter int unsigned IM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        IM_we,
    output logic [31:0] IM_addr,
    output logic [31:0] IM_data,
    output logic        cpu_rst,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int unsigned IdleW = $clog2(TIMEOUT + 1);

    state_e              state_q, state_d;
    logic [CountW-1:0]   cnt_q;
    logic [CountW-1:0]   word_idx_q;
    logic [7:0]          csum_q;
    logic [IdleW-1:0]    idle_q;
    logic [31:0]         addr_q;
    logic                busy_q, done_q, err_q, cpu_rst_q;

    logic                arm, in_data, counting, timed_out, last_byte;
    logic [CountW-1:0]   count_full;

    assign arm       = start && (state_q inside {StIdle, StDone, StErr});
    assign in_data   = rx_valid && (state_q == StData);
    assign counting  = state_q inside {StCntLo, StCntHi, StData, StCsum};
    assign timed_out = !rx_valid && (idle_q == IdleW'(TIMEOUT - 1));
    assign count_full = {rx_data, cnt_q[7:0]};

    word_assembler u_word_assembler (
        .clk_i        (clk),
        .rst_i        (rst),
        .clear_i      (arm),
        .byte_valid_i (in_data),
        .byte_data_i  (rx_data),
        .last_byte_o  (last_byte),
        .word_valid_o (IM_we),
        .word_o       (IM_data)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StDone, StErr: if (start) state_d = StMagic;
            StMagic: if (rx_valid && rx_data == MagicByte) state_d = StCntLo;
            StCntLo: begin
                if (rx_valid)       state_d = StCntHi;
                else if (timed_out) state_d = StErr;
            end
            StCntHi: begin
                if (rx_valid) begin
                    if (32'(count_full) > IM_WORDS) state_d = StErr;
                    else if (count_full == '0)     state_d = StCsum;
                    else                           state_d = StData;
                end else if (timed_out) begin
                    state_d = StErr;
                end
            end
            StData: begin
                if (rx_valid) begin
                    if (last_byte && word_idx_q == cnt_q - 16'd1) state_d = StCsum;
                end else if (timed_out) begin
                    state_d = StErr;
                end
            end
            StCsum: begin
                if (rx_valid)       state_d = (rx_data == csum_q) ? StDone : StErr;
                else if (timed_out) state_d = StErr;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            word_idx_q <= '0;
            csum_q     <= 8'd0;
            idle_q     <= '0;
            addr_q     <= 32'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cpu_rst_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            // Status flags track the state being entered so they line up with state_q.
            busy_q    <= state_d inside {StMagic, StCntLo, StCntHi, StData, StCsum};
            done_q    <= (state_d == StDone);
            err_q     <= (state_d == StErr);
            cpu_rst_q <= (state_d != StDone);
            if (arm) begin
                cnt_q      <= '0;
                word_idx_q <= '0;
                csum_q     <= 8'd0;
                idle_q     <= '0;
            end else begin
                if (counting) idle_q <= rx_valid ? '0 : idle_q + IdleW'(1);
                if (rx_valid && state_q == StCntLo) cnt_q[7:0]  <= rx_data;
                if (rx_valid && state_q == StCntHi) cnt_q[15:8] <= rx_data;
                if (in_data) begin
                    csum_q <= csum_q ^ rx_data;
                    if (last_byte) begin
                        addr_q     <= {14'd0, word_idx_q, 2'b00};
                        word_idx_q <= word_idx_q + 16'd1;
                    end
                end
            end
        end
    end

    assign IM_addr = addr_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign cpu_rst = cpu_rst_q;

endmodule

// File: tb/tb_program_loader.sv
// Scenario bench for program_loader: expected IM writes go into a scoreboard
// queue as frames are sent and are popped when IM_we is observed.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        IM_we;
    logic [31:0] IM_addr;
    logic [31:0] IM_data;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        err;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  compared   = 0;
    int  mismatched = 0;

    always #5 clk = ~clk;

    program_loader #(
        .TIMEOUT  (16),
        .IM_WORDS (256)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .IM_we    (IM_we),
        .IM_addr  (IM_addr),
        .IM_data  (IM_data),
        .cpu_rst  (cpu_rst),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    // Every observed write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (IM_we === 1'b1) begin
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL im_write_unexpected: got addr=%h data=%h, required none",
                         IM_addr, IM_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (IM_addr !== e.addr || IM_data !== e.data) begin
                    mismatched++;
                    $display("FAIL im_write: got addr=%h data=%h, required addr=%h data=%h",
                             IM_addr, IM_data, e.addr, e.data);
                end
            end
        end
    end

    task send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] n, input logic [31:0] w0,
                              input logic [31:0] w1, input logic [7:0] flip);
        logic [7:0]  cs;
        logic [31:0] w;
        cs = 8'h00;
        send_byte(8'hA5);
        send_byte(n[7:0]);
        send_byte(n[15:8]);
        for (int k = 0; k < int'(n); k++) begin
            w = (k == 0) ? w0 : w1;
            for (int i = 0; i < 4; i++) begin
                if (i == 3) exp_q.push_back('{addr: 32'(4 * k), data: w});
                cs = cs ^ w[8*i +: 8];
                send_byte(w[8*i +: 8]);
            end
        end
        send_byte(cs ^ flip);
    endtask

    task test_reset();
        rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        compared++;
        if ({IM_we, busy, done, err, cpu_rst} !== 5'b00001) begin
            mismatched++;
            $display("FAIL reset_flags: got we/busy/done/err/cpu_rst=%b, required 00001",
                     {IM_we, busy, done, err, cpu_rst});
        end
        compared++;
        if (IM_addr !== 32'd0 || IM_data !== 32'd0) begin
            mismatched++;
            $display("FAIL reset_bus: got addr=%h data=%h, required 0/0", IM_addr, IM_data);
        end
    endtask

    task test_basic_load();
        pulse_start();
        compared++;
        if (busy !== 1'b1 || cpu_rst !== 1'b1) begin
            mismatched++;
            $display("FAIL s1_armed: got busy=%b cpu_rst=%b, required 1/1", busy, cpu_rst);
        end
        send_frame(16'd2, 32'h0000_0013, 32'h0010_0093, 8'h00);
        compared++;
        if ({done, err, cpu_rst, busy} !== 4'b1000) begin
            mismatched++;
            $display("FAIL s1_done: got done/err/cpu_rst/busy=%b, required 1000",
                     {done, err, cpu_rst, busy});
        end
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL s1_writes: got %0d writes missing, required 0", exp_q.size());
        end
    endtask

    task test_leading_junk_empty();
        pulse_start();
        compared++;
        if (cpu_rst !== 1'b1 || done !== 1'b0) begin
            mismatched++;
            $display("FAIL s2_rearm: got cpu_rst=%b done=%b, required 1/0", cpu_rst, done);
        end
        send_byte(8'h00);
        send_byte(8'hFF);
        compared++;
        if (busy !== 1'b1 || err !== 1'b0) begin
            mismatched++;
            $display("FAIL s2_junk: got busy=%b err=%b, required 1/0", busy, err);
        end
        send_frame(16'd0, 32'd0, 32'd0, 8'h00);
        compared++;
        if (done !== 1'b1 || cpu_rst !== 1'b0) begin
            mismatched++;
            $display("FAIL s2_done: got done=%b cpu_rst=%b, required 1/0", done, cpu_rst);
        end
    endtask

    task test_bad_checksum();
        pulse_start();
        send_frame(16'd2, 32'h0000_0013, 32'h0010_0093, 8'h11);
        compared++;
        if ({done, err, cpu_rst} !== 3'b011) begin
            mismatched++;
            $display("FAIL s3_err: got done/err/cpu_rst=%b, required 011", {done, err, cpu_rst});
        end
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL s3_writes: got %0d writes missing, required 0", exp_q.size());
        end
        pulse_start();
        send_frame(16'd1, 32'hDEAD_BEEF, 32'd0, 8'h00);
        compared++;
        if (done !== 1'b1 || err !== 1'b0) begin
            mismatched++;
            $display("FAIL s3_recover: got done=%b err=%b, required 1/0", done, err);
        end
    endtask

    task test_timeout();
        pulse_start();
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h13);
        send_byte(8'h00);
        repeat (15) @(negedge clk);
        compared++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            mismatched++;
            $display("FAIL s4_early: got err=%b busy=%b after 15 idle, required 0/1", err, busy);
        end
        @(negedge clk);
        compared++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL s4_timeout: got err=%b busy=%b after 16 idle, required 1/0", err, busy);
        end
    endtask

    task test_oversize();
        pulse_start();
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h01);
        compared++;
        if (err !== 1'b1 || cpu_rst !== 1'b1) begin
            mismatched++;
            $display("FAIL s5_oversize: got err=%b cpu_rst=%b, required 1/1", err, cpu_rst);
        end
        send_byte(8'h13);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
    endtask

    task test_reset_mid_load();
        pulse_start();
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h00);
        exp_q.push_back('{addr: 32'h0, data: 32'h4433_2211});
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h55); send_byte(8'h66);
        @(negedge clk);
        rx_valid = 1'b1; rx_data = 8'h77; rst = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0; rst = 1'b0;
        compared++;
        if ({IM_we, busy, done, err, cpu_rst} !== 5'b00001 || IM_addr !== 32'd0
            || IM_data !== 32'd0) begin
            mismatched++;
            $display("FAIL s6_reset: got flags=%b addr=%h data=%h, required 00001/0/0",
                     {IM_we, busy, done, err, cpu_rst}, IM_addr, IM_data);
        end
        send_byte(8'h88);
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        compared++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            mismatched++;
            $display("FAIL s6_ignored: got busy=%b done=%b err=%b, required 0/0/0",
                     busy, done, err);
        end
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL s6_writes: got %0d writes missing, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_leading_junk_empty();
        test_bad_checksum();
        test_timeout();
        test_oversize();
        test_reset_mid_load();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
